fifo_ptr_status_ctrl: RTL and testbench

Synchronous FIFO pointer and status controller, parametrised in depth, with registered flags. It owns the write and read pointers, each ADDR_WIDTH+1 bits with the MSB used as the wrap bit. It generates full, empty, almost-full, almost-empty, fill level and sticky overflow/underflow error flags. It sits between the FIFO client interface and the dual-port memory, and its pointer LSBs drive the memory addresses directly.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_flag_gen.sv | 37 +++
 rtl/fifo_ptr_status_ctrl.sv | 145 ++++++++++++++
 tb/tb_fifo_ptr_status_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO controller family.
// Holds the pointer-width helper, default almost-full/almost-empty
// thresholds, and the status record produced by the flag generator.
// The status count field is sized for the largest supported depth so
// that other FIFO variants (e.g. dual-clock) can reuse the same record.
package fifo_pkg;

  // Default thresholds for an 8-entry FIFO.
  localparam int unsigned FIFO_AF_THRESH_DEF = 6;
  localparam int unsigned FIFO_AE_THRESH_DEF = 2;

  // Widest occupancy count any variant may carry in the status record.
  localparam int unsigned FIFO_CNT_W = 16;

  // Pointers carry one extra wrap bit above the memory address bits.
  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

  typedef struct packed {
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [FIFO_CNT_W-1:0] count;
  } fifo_status_t;

endpackage

// File: rtl/fifo_flag_gen.sv
// Combinational status generator.
// Derives full/empty/almost flags and occupancy from the *next* write and
// read pointers so the parent can register them alongside the pointers.
// Ports:
//   wptr_nxt   in  ADDR_WIDTH+1  next write pointer (MSB = wrap bit)
//   rptr_nxt   in  ADDR_WIDTH+1  next read pointer  (MSB = wrap bit)
//   status_nxt out fifo_status_t next-state flags and count
module fifo_flag_gen
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = FIFO_AF_THRESH_DEF,
  parameter int unsigned AE_THRESH  = FIFO_AE_THRESH_DEF
) (
  input  logic [ADDR_WIDTH:0] wptr_nxt,
  input  logic [ADDR_WIDTH:0] rptr_nxt,
  output fifo_status_t        status_nxt
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] AF_T = PW'(AF_THRESH);
  localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

  logic [PW-1:0] count_s;

  // Next-state status from next pointers; count is the modulo difference.
  always_comb begin
    count_s                 = wptr_nxt - rptr_nxt;
    status_nxt.full         = (wptr_nxt[ADDR_WIDTH] != rptr_nxt[ADDR_WIDTH]) &&
                              (wptr_nxt[ADDR_WIDTH-1:0] == rptr_nxt[ADDR_WIDTH-1:0]);
    status_nxt.empty        = (wptr_nxt == rptr_nxt);
    status_nxt.almost_full  = (count_s >= AF_T);
    status_nxt.almost_empty = (count_s <= AE_T);
    status_nxt.count        = FIFO_CNT_W'(count_s);
  end

endmodule

// File: rtl/fifo_ptr_status_ctrl.sv
// Synchronous FIFO pointer and status controller.
// Owns the write/read pointers (ADDR_WIDTH+1 bits, MSB = wrap bit) and
// keeps registered full/empty/almost flags and fill level that are valid
// in the same cycle as the updated pointers. Sticky overflow/underflow
// record requests made against a full/empty FIFO.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   wr_en, rd_en     client write / read requests
//   clr_err          clears sticky overflow/underflow
//   waddr, raddr     memory addresses (pointer LSBs)
//   wr_ack, rd_ack   combinational accept strobes
//   fifo_full, fifo_empty, almost_full, almost_empty, fill_count  registered status
//   overflow, underflow  sticky error flags
module fifo_ptr_status_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned AF_THRESH  = FIFO_AF_THRESH_DEF,
  parameter int unsigned AE_THRESH  = FIFO_AE_THRESH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  wr_ack,
  output logic                  rd_ack,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   fill_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] wptr_r;
  logic [PW-1:0] rptr_r;
  logic [PW-1:0] wptr_nxt_s;
  logic [PW-1:0] rptr_nxt_s;
  logic          full_r;
  logic          empty_r;
  logic          almost_full_r;
  logic          almost_empty_r;
  logic [PW-1:0] count_r;
  logic          overflow_r;
  logic          underflow_r;
  logic          overflow_nxt_s;
  logic          underflow_nxt_s;
  fifo_status_t  status_nxt_s;
  logic          unused_cnt_hi_s;

  // Accepts are gated by the registered flags of the current cycle.
  assign wr_ack = wr_en & ~full_r;
  assign rd_ack = rd_en & ~empty_r;

  // Next pointers: advance only on an accepted request, modulo 2**PW.
  always_comb begin
    wptr_nxt_s = wptr_r;
    rptr_nxt_s = rptr_r;
    if (wr_ack) begin
      wptr_nxt_s = wptr_r + PW'(1);
    end else begin
      wptr_nxt_s = wptr_r;
    end
    if (rd_ack) begin
      rptr_nxt_s = rptr_r + PW'(1);
    end else begin
      rptr_nxt_s = rptr_r;
    end
  end

  // Sticky errors: a new set condition beats a simultaneous clear.
  always_comb begin
    overflow_nxt_s  = overflow_r;
    underflow_nxt_s = underflow_r;
    if (wr_en && full_r) begin
      overflow_nxt_s = 1'b1;
    end else if (clr_err) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    if (rd_en && empty_r) begin
      underflow_nxt_s = 1'b1;
    end else if (clr_err) begin
      underflow_nxt_s = 1'b0;
    end else begin
      underflow_nxt_s = underflow_r;
    end
  end

  fifo_flag_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_flag_gen (
    .wptr_nxt   (wptr_nxt_s),
    .rptr_nxt   (rptr_nxt_s),
    .status_nxt (status_nxt_s)
  );

  // The shared status record carries a wider count than this depth needs.
  assign unused_cnt_hi_s = |status_nxt_s.count[FIFO_CNT_W-1:PW];

  // State register: pointers, flags and errors update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r         <= {PW{1'b0}};
      rptr_r         <= {PW{1'b0}};
      full_r         <= 1'b0;
      empty_r        <= 1'b1;
      almost_full_r  <= 1'b0;
      almost_empty_r <= 1'b1;
      count_r        <= {PW{1'b0}};
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      wptr_r         <= wptr_nxt_s;
      rptr_r         <= rptr_nxt_s;
      full_r         <= status_nxt_s.full;
      empty_r        <= status_nxt_s.empty;
      almost_full_r  <= status_nxt_s.almost_full;
      almost_empty_r <= status_nxt_s.almost_empty;
      count_r        <= status_nxt_s.count[PW-1:0];
      overflow_r     <= overflow_nxt_s;
      underflow_r    <= underflow_nxt_s;
    end
  end

  assign waddr        = wptr_r[ADDR_WIDTH-1:0];
  assign raddr        = rptr_r[ADDR_WIDTH-1:0];
  assign fifo_full    = full_r;
  assign fifo_empty   = empty_r;
  assign almost_full  = almost_full_r;
  assign almost_empty = almost_empty_r;
  assign fill_count   = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_ptr_status_ctrl.sv
// Directed bench for fifo_ptr_status_ctrl with ADDR_WIDTH=3, AF=6, AE=2.
// Inputs change at the falling edge; registered outputs are sampled 1
// time unit after the rising edge.
module tb_fifo_ptr_status_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [2:0] waddr;
  logic [2:0] raddr;
  logic       wr_ack;
  logic       rd_ack;
  logic       fifo_full;
  logic       fifo_empty;
  logic       almost_full;
  logic       almost_empty;
  logic [3:0] fill_count;
  logic       overflow;
  logic       underflow;

  int tests = 0;
  int fails = 0;

  fifo_ptr_status_ctrl #(
    .ADDR_WIDTH (3),
    .AF_THRESH  (6),
    .AE_THRESH  (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .clr_err      (clr_err),
    .waddr        (waddr),
    .raddr        (raddr),
    .wr_ack       (wr_ack),
    .rd_ack       (rd_ack),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fill_count   (fill_count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs at the falling edge; combinational acks are
  // stable 1 unit later.
  task automatic drive(input logic w, input logic r, input logic c, input logic s);
    @(negedge clk);
    wr_en   = w;
    rd_en   = r;
    clr_err = c;
    rst     = s;
    #1;
  endtask

  // Let the rising edge take the inputs, then return to idle.
  task automatic tick();
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst     = 1'b0;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    // Reset wins over all other inputs.
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tests++; if (fifo_empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b want 1", fifo_empty); end
    tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae got %b want 1", almost_empty); end
    tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL reset_full got %b want 0", fifo_full); end
    tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af got %b want 0", almost_full); end
    tests++; if (fill_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", fill_count); end
    tests++; if (waddr !== 3'd0 || raddr !== 3'd0) begin fails++; $display("FAIL reset_addr got %0d/%0d want 0/0", waddr, raddr); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL reset_err got %b%b want 00", overflow, underflow); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tests++; if (wr_ack !== 1'b1) begin fails++; $display("FAIL fill_ack%0d got %b want 1", i, wr_ack); end
      tick();
      tests++; if (fill_count !== 4'(i)) begin fails++; $display("FAIL fill_count%0d got %0d want %0d", i, fill_count, i); end
      tests++; if (almost_empty !== (i <= 2)) begin fails++; $display("FAIL fill_ae%0d got %b want %b", i, almost_empty, (i <= 2)); end
      tests++; if (almost_full !== (i >= 6)) begin fails++; $display("FAIL fill_af%0d got %b want %b", i, almost_full, (i >= 6)); end
      tests++; if (fifo_full !== (i == 8)) begin fails++; $display("FAIL fill_full%0d got %b want %b", i, fifo_full, (i == 8)); end
      tests++; if (fifo_empty !== 1'b0) begin fails++; $display("FAIL fill_empty%0d got %b want 0", i, fifo_empty); end
      tests++; if (waddr !== 3'(i)) begin fails++; $display("FAIL fill_waddr%0d got %0d want %0d", i, waddr, i % 8); end
    end
    // Ninth write is refused.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (wr_ack !== 1'b0) begin fails++; $display("FAIL ovf_ack got %b want 0", wr_ack); end
    tick();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b want 1", overflow); end
    tests++; if (dut.wptr_r !== 4'd8) begin fails++; $display("FAIL ovf_wptr got %0d want 8", dut.wptr_r); end
    tests++; if (fill_count !== 4'd8 || fifo_full !== 1'b1) begin fails++; $display("FAIL ovf_state got %0d/%b want 8/1", fill_count, fifo_full); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tests++; if (rd_ack !== 1'b1) begin fails++; $display("FAIL drain_ack%0d got %b want 1", i, rd_ack); end
      tick();
      tests++; if (fill_count !== 4'(8 - i)) begin fails++; $display("FAIL drain_count%0d got %0d want %0d", i, fill_count, 8 - i); end
      tests++; if (fifo_full !== 1'b0) begin fails++; $display("FAIL drain_full%0d got %b want 0", i, fifo_full); end
      tests++; if (fifo_empty !== (i == 8)) begin fails++; $display("FAIL drain_empty%0d got %b want %b", i, fifo_empty, (i == 8)); end
      tests++; if (raddr !== 3'(i)) begin fails++; $display("FAIL drain_raddr%0d got %0d want %0d", i, raddr, i % 8); end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (rd_ack !== 1'b0) begin fails++; $display("FAIL unf_ack got %b want 0", rd_ack); end
    tick();
    tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL unf_flag got %b want 1", underflow); end
    tests++; if (dut.wptr_r !== 4'd8 || dut.rptr_r !== 4'd8) begin fails++; $display("FAIL unf_ptrs got %0d/%0d want 8/8", dut.wptr_r, dut.rptr_r); end
    tests++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0) begin fails++; $display("FAIL unf_flags got e%b f%b want e1 f0", fifo_empty, fifo_full); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, 1'b0, 1'b0); tick(); end
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      if (i == 3) begin
        tests++; if (waddr !== 3'd0) begin fails++; $display("FAIL wrap_waddr got %0d want 0", waddr); end
      end
    end
    tests++; if (fifo_full !== 1'b1) begin fails++; $display("FAIL wrap_full got %b want 1", fifo_full); end
    tests++; if (dut.wptr_r !== 4'd13 || dut.rptr_r !== 4'd5) begin fails++; $display("FAIL wrap_ptrs got %0d/%0d want 13/5", dut.wptr_r, dut.rptr_r); end
    tests++; if (fill_count !== 4'd8) begin fails++; $display("FAIL wrap_count got %0d want 8", fill_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (wr_ack !== 1'b1 || rd_ack !== 1'b1) begin fails++; $display("FAIL sim4_acks got %b%b want 11", wr_ack, rd_ack); end
    tick();
    tests++; if (fill_count !== 4'd4) begin fails++; $display("FAIL sim4_count got %0d want 4", fill_count); end
    tests++; if (waddr !== 3'd5 || raddr !== 3'd1) begin fails++; $display("FAIL sim4_addr got %0d/%0d want 5/1", waddr, raddr); end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (wr_ack !== 1'b0 || rd_ack !== 1'b1) begin fails++; $display("FAIL simfull_acks got %b%b want 01", wr_ack, rd_ack); end
    tick();
    tests++; if (fill_count !== 4'd7 || overflow !== 1'b1 || fifo_full !== 1'b0) begin fails++; $display("FAIL simfull got cnt%0d ovf%b full%b want cnt7 ovf1 full0", fill_count, overflow, fifo_full); end
    do_reset();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin fails++; $display("FAIL simempty_acks got %b%b want 10", wr_ack, rd_ack); end
    tick();
    tests++; if (fill_count !== 4'd1 || underflow !== 1'b1 || fifo_empty !== 1'b0) begin fails++; $display("FAIL simempty got cnt%0d unf%b empty%b want cnt1 unf1 empty0", fill_count, underflow, fifo_empty); end
  endtask

  task automatic test_clr_err();
    // Count is 1 with underflow set; fill to full and overflow it.
    for (int i = 0; i < 7; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    drive(1'b1, 1'b0, 1'b0, 1'b0); tick();
    tests++; if (overflow !== 1'b1 || underflow !== 1'b1) begin fails++; $display("FAIL clr_pre got %b%b want 11", overflow, underflow); end
    drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL clr_clear got %b%b want 00", overflow, underflow); end
    drive(1'b1, 1'b0, 1'b1, 1'b0); tick();
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL clr_setwins got %b want 1", overflow); end
    tests++; if (fill_count !== 4'd8) begin fails++; $display("FAIL clr_count got %0d want 8", fill_count); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 5; i++) begin drive(1'b1, 1'b0, 1'b0, 1'b0); tick(); end
    tests++; if (fill_count !== 4'd5) begin fails++; $display("FAIL mid_pre got %0d want 5", fill_count); end
    drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
    tests++; if (fill_count !== 4'd0 || fifo_empty !== 1'b1 || almost_empty !== 1'b1) begin fails++; $display("FAIL mid_rst got cnt%0d e%b ae%b want cnt0 e1 ae1", fill_count, fifo_empty, almost_empty); end
    tests++; if (fifo_full !== 1'b0 || almost_full !== 1'b0 || waddr !== 3'd0 || raddr !== 3'd0) begin fails++; $display("FAIL mid_rst2 got f%b af%b wa%0d ra%0d want 0 0 0 0", fifo_full, almost_full, waddr, raddr); end
    tests++; if (overflow !== 1'b0 || underflow !== 1'b0) begin fails++; $display("FAIL mid_rst_err got %b%b want 00", overflow, underflow); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_wrap();
    test_simultaneous();
    test_clr_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
